accumulator_stage: RTL and testbench

ACCUMULATOR_STAGE -- requirements
Module: accumulator_stage

---
 rtl/accumulator_stage_pkg.sv | 17 +
 rtl/structural_adder.sv | 23 ++
 rtl/accumulator_stage.sv | 86 ++++++++
 tb/tb_accumulator_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_stage_pkg.sv
// Shared definitions for the accumulator stage and its bench.
// Holds the state encodings, the state type and the beat counter width.
package accumulator_stage_pkg;

    // State encodings, shared by the stage and the bench
    localparam logic StateAccumEnc = 1'b0;
    localparam logic StateDoneEnc  = 1'b1;

    // Width of the beat counter; also bounds the legal burst length (1..255)
    localparam int unsigned CountWidth = 8;

    typedef enum logic {
        StAccum = StateAccumEnc,
        StDone  = StateDoneEnc
    } acc_state_e;

endpackage

// File: rtl/structural_adder.sv
// N-bit ripple-carry adder.
// Produces an N+1-bit result whose top bit is the carry-out.
module structural_adder #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    // Bit-serial full-adder chain, carry rippling from bit 0 upward
    always_comb begin
        logic c;
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        sum[N] = c;
    end

endmodule

// File: rtl/accumulator_stage.sv
// Burst accumulator: sums BURST accepted beats modulo 2^N, tracks a sticky
// carry-out, then holds the result until downstream consumes it.
module accumulator_stage
    import accumulator_stage_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_sum,
    output logic         out_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   count
);

    // Count value held just before the final beat of a burst
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(BURST - 1);

    acc_state_e      state_q;
    logic [N-1:0]    acc_q;
    logic            ovf_q;
    logic [7:0]      count_q;
    logic [N:0]      add_sum;
    logic            xfer;
    logic            last_beat;

    structural_adder #(
        .N (N)
    ) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum)
    );

    // Handshake decode depends on state only
    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign xfer      = in_valid && in_ready;
    assign last_beat = (count_q == LastCount);

    assign out_sum = acc_q;
    assign out_ovf = ovf_q;
    assign count   = count_q;

    // FSM and datapath registers; reset wins over transfer and consume
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (xfer) begin
                        acc_q   <= add_sum[N-1:0];
                        ovf_q   <= ovf_q | add_sum[N];
                        count_q <= count_q + 8'd1;
                        if (last_beat) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Consume clears everything; the input is not looked at
                    // this cycle, so the next burst starts on the following edge
                    if (out_ready) begin
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                        state_q <= StAccum;
                    end
                end
                default: begin
                    state_q <= StAccum;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_stage.sv
// Directed bench for accumulator_stage: a BURST=4 instance and a BURST=1
// instance, each feature exercised by its own task with inline checks.
module tb_accumulator_stage;
    import accumulator_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_sum;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  count;

    logic [31:0] in_data1;
    logic        in_valid1;
    logic        in_ready1;
    logic [31:0] out_sum1;
    logic        out_ovf1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  count1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accumulator_stage #(
        .N     (32),
        .BURST (4)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    accumulator_stage #(
        .N     (32),
        .BURST (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .out_sum   (out_sum1),
        .out_ovf   (out_ovf1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .count     (count1)
    );

    // Advance one clock; outputs are stable 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat on the BURST=4 instance for a single edge
    task automatic beat(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 32'd77; out_ready = 1'b1;
        in_valid1 = 1'b1; in_data1 = 32'd55; out_ready1 = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; in_valid1 = 1'b0;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (out_sum !== 32'd0) begin failures++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
        checks++;
        if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got %0b want 0", out_ovf); end
        checks++;
        if (count !== 8'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (dut4.state_q !== StAccum) begin failures++; $display("FAIL reset_state got %0b want %0b", dut4.state_q, StateAccumEnc); end
        checks++;
        if (out_sum1 !== 32'd0 || count1 !== 8'd0 || in_ready1 !== 1'b1) begin
            failures++; $display("FAIL reset_b1 got sum=%0d count=%0d rdy=%0b want 0 0 1", out_sum1, count1, in_ready1);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        beat(32'd1000);
        checks++;
        if (count !== 8'd1) begin failures++; $display("FAIL b2b_count1 got %0d want 1", count); end
        beat(32'd1000);
        beat(32'd2000);
        checks++;
        if (out_valid !== 1'b0 || count !== 8'd3) begin
            failures++; $display("FAIL b2b_beat3 got valid=%0b count=%0d want 0 3", out_valid, count);
        end
        beat(32'd3000);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got %0b want 1", out_valid); end
        checks++;
        if (out_sum !== 32'd7000) begin failures++; $display("FAIL b2b_sum got %0d want 7000", out_sum); end
        checks++;
        if (out_ovf !== 1'b0 || count !== 8'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_done got ovf=%0b count=%0d rdy=%0b want 0 4 0", out_ovf, count, in_ready);
        end
        checks++;
        if (dut4.state_q !== StDone) begin failures++; $display("FAIL b2b_state got %0b want %0b", dut4.state_q, StateDoneEnc); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 8'd0 || out_sum !== 32'd0) begin
            failures++; $display("FAIL b2b_consume got valid=%0b count=%0d sum=%0d want 0 0 0", out_valid, count, out_sum);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        beat(32'hFFFF_FFFF);
        beat(32'd2);
        checks++;
        if (out_ovf !== 1'b1 || out_sum !== 32'd1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL ovf_mid got ovf=%0b sum=%0d valid=%0b want 1 1 0", out_ovf, out_sum, out_valid);
        end
        beat(32'd0);
        beat(32'd0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd1 || out_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_result got valid=%0b sum=%0d ovf=%0b want 1 1 1", out_valid, out_sum, out_ovf);
        end
        tick();
        for (int i = 0; i < 4; i++) beat(32'd1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd4 || out_ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_next got valid=%0b sum=%0d ovf=%0b want 1 4 0", out_valid, out_sum, out_ovf);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) beat(i);
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 32'd10 || in_ready !== 1'b0 || count !== 8'd4) begin
                failures++;
                $display("FAIL hold_%0d got valid=%0b sum=%0d rdy=%0b count=%0d want 1 10 0 4",
                         i, out_valid, out_sum, in_ready, count);
            end
        end
        // Consume with in_valid still high: the beat must not be taken
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 8'd0 || out_sum !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_bypass got valid=%0b count=%0d sum=%0d rdy=%0b want 0 0 0 1",
                     out_valid, count, out_sum, in_ready);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'd5);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd20) begin
            failures++; $display("FAIL after_hold got valid=%0b sum=%0d want 1 20", out_valid, out_sum);
        end
        tick();
    endtask

    task automatic test_gapped();
        logic [31:0] vals [4];
        vals = '{32'd10, 32'd20, 32'd30, 32'd40};
        for (int i = 0; i < 4; i++) begin
            beat(vals[i]);
            checks++;
            if (count !== 8'(i + 1)) begin failures++; $display("FAIL gap_step%0d got %0d want %0d", i, count, i + 1); end
            if (i < 3) begin
                in_data = 32'hDEAD_BEEF;
                out_ready = (i % 2 == 0);
                tick();
                tick();
                out_ready = 1'b1;
                checks++;
                if (count !== 8'(i + 1) || out_valid !== 1'b0) begin
                    failures++; $display("FAIL gap_idle%0d got count=%0d valid=%0b want %0d 0", i, count, out_valid, i + 1);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd100) begin
            failures++; $display("FAIL gap_result got valid=%0b sum=%0d want 1 100", out_valid, out_sum);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        beat(32'd5);
        beat(32'd6);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd7;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 8'd0 || out_sum !== 32'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL midrst got count=%0d sum=%0d valid=%0b want 0 0 0", count, out_sum, out_valid);
        end
        for (int i = 1; i <= 4; i++) beat(i);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd10) begin
            failures++; $display("FAIL midrst_next got valid=%0b sum=%0d want 1 10", out_valid, out_sum);
        end
        // Reset while holding a result drops it without a consume
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 32'd0) begin
            failures++; $display("FAIL done_rst got valid=%0b sum=%0d want 0 0", out_valid, out_sum);
        end
    endtask

    task automatic test_burst1();
        out_ready1 = 1'b1;
        in_valid1 = 1'b1;
        in_data1 = 32'd5;
        tick();
        in_data1 = 32'd7;
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== 32'd5 || in_ready1 !== 1'b0 || out_ovf1 !== 1'b0) begin
            failures++; $display("FAIL b1_first got valid=%0b sum=%0d rdy=%0b ovf=%0b want 1 5 0 0",
                                 out_valid1, out_sum1, in_ready1, out_ovf1);
        end
        tick();
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            failures++; $display("FAIL b1_consume got valid=%0b rdy=%0b want 0 1", out_valid1, in_ready1);
        end
        tick();
        in_data1 = 32'hFFFF_FFFF;
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== 32'd7 || in_ready1 !== 1'b0) begin
            failures++; $display("FAIL b1_second got valid=%0b sum=%0d rdy=%0b want 1 7 0", out_valid1, out_sum1, in_ready1);
        end
        tick();
        tick();
        in_valid1 = 1'b0;
        checks++;
        if (out_sum1 !== 32'hFFFF_FFFF || out_ovf1 !== 1'b0 || count1 !== 8'd1) begin
            failures++; $display("FAIL b1_max got sum=%h ovf=%0b count=%0d want ffffffff 0 1", out_sum1, out_ovf1, count1);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        test_reset();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_gapped();
        test_mid_reset();
        test_burst1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
